// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Shares one memory-mapped IO device port between N_REQ requesters.
//   Round-robin arbitration picks one request at a time; the request is
//   registered and presented to the device for exactly one cycle. A single
//   outstanding read is tracked until the device answers or a timeout fires,
//   and the response is returned to the requester that issued it.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   req_valid/write            per-requester request pending / 1=write
//   req_address/data           per-requester address/data, requester i at slice i
//   req_grant                  one-hot pulse, request accepted this cycle
//   resp_valid                 one-hot pulse, read response for requester i
//   resp_error                 qualifies resp_valid: timeout, data is zero
//   resp_address/data          shared response address/data (held until next response)
//   n2m_request_*              request towards the device
//   mc_avail_o                 arbiter will accept a device response
//   m2n_request_available      device can take a request
//   m2n_response_*             response from the device
module io_bus_arbiter #(
    parameter int N_REQ         = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int BUS_WIDTH     = 512,
    parameter int TIMEOUT       = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_REQ-1:0]                 req_valid,
    input  logic [N_REQ-1:0]                 req_write,
    input  logic [N_REQ*ADDRESS_WIDTH-1:0]   req_address,
    input  logic [N_REQ*BUS_WIDTH-1:0]       req_data,
    output logic [N_REQ-1:0]                 req_grant,
    output logic [N_REQ-1:0]                 resp_valid,
    output logic                             resp_error,
    output logic [ADDRESS_WIDTH-1:0]         resp_address,
    output logic [BUS_WIDTH-1:0]             resp_data,
    output logic [ADDRESS_WIDTH-1:0]         n2m_request_address,
    output logic [BUS_WIDTH-1:0]             n2m_request_data,
    output logic                             n2m_request_read,
    output logic                             n2m_request_write,
    output logic                             mc_avail_o,
    input  logic                             m2n_request_available,
    input  logic                             m2n_response_valid,
    input  logic [ADDRESS_WIDTH-1:0]         m2n_response_address,
    input  logic [BUS_WIDTH-1:0]             m2n_response_data
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP,
        RESP
    } state_t;

    state_t                   state;
    logic [PTR_W-1:0]         rr_ptr;
    logic [PTR_W-1:0]         owner;
    logic [PTR_W-1:0]         winner;
    logic                     win_found;
    logic                     arb_go;
    logic [15:0]              timer;
    logic                     hold_write;
    logic [ADDRESS_WIDTH-1:0] sel_address;
    logic [BUS_WIDTH-1:0]     sel_data;
    logic                     sel_write;

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (idx == PTR_W'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Round-robin search: the requester just after the last winner has the
    // highest priority, wrapping modulo N_REQ.
    always_comb begin
        int               cand;
        logic [PTR_W-1:0] cand_ptr;
        winner    = '0;
        win_found = 1'b0;
        cand      = 0;
        cand_ptr  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            cand_ptr = PTR_W'(cand);
            if (!win_found && req_valid[cand_ptr]) begin
                winner    = cand_ptr;
                win_found = 1'b1;
            end
        end
    end

    // Mux the winner's request fields.
    always_comb begin
        sel_address = '0;
        sel_data    = '0;
        sel_write   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == PTR_W'(i)) begin
                sel_address = req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_data    = req_data[i*BUS_WIDTH +: BUS_WIDTH];
                sel_write   = req_write[i];
            end
        end
    end

    assign arb_go = (state == IDLE) && m2n_request_available && win_found;

    // The grant is combinational; gating with reset keeps it low while the
    // block is held in reset even if requests are pending.
    always_comb begin
        req_grant = '0;
        if (arb_go && reset) req_grant = onehot(winner);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            rr_ptr              <= PTR_W'(N_REQ - 1);
            owner               <= '0;
            timer               <= '0;
            hold_write          <= 1'b0;
            n2m_request_address <= '0;
            n2m_request_data    <= '0;
            n2m_request_read    <= 1'b0;
            n2m_request_write   <= 1'b0;
            mc_avail_o          <= 1'b0;
            resp_valid          <= '0;
            resp_error          <= 1'b0;
            resp_address        <= '0;
            resp_data           <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            n2m_request_read  <= 1'b0;
            n2m_request_write <= 1'b0;
            resp_valid        <= '0;
            case (state)
                IDLE: begin
                    if (arb_go) begin
                        n2m_request_address <= sel_address;
                        n2m_request_data    <= sel_data;
                        hold_write          <= sel_write;
                        n2m_request_write   <= sel_write;
                        n2m_request_read    <= !sel_write;
                        owner               <= winner;
                        rr_ptr              <= winner;
                        state               <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (hold_write) begin
                        state <= IDLE;
                    end else begin
                        timer      <= '0;
                        mc_avail_o <= 1'b1;
                        state      <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    // A real response wins over a timeout landing in the same cycle.
                    if (m2n_response_valid) begin
                        resp_address <= m2n_response_address;
                        resp_data    <= m2n_response_data;
                        resp_error   <= 1'b0;
                        resp_valid   <= onehot(owner);
                        mc_avail_o   <= 1'b0;
                        state        <= RESP;
                    end else if (timer == 16'(TIMEOUT - 1)) begin
                        resp_address <= n2m_request_address;
                        resp_data    <= '0;
                        resp_error   <= 1'b1;
                        resp_valid   <= onehot(owner);
                        mc_avail_o   <= 1'b0;
                        state        <= RESP;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RESP: begin
                    resp_error <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
